// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter: grants, decodes the slave ID, holds the bus until done or timeout.
// Latency: req -> grant 1 cycle, slv_sel/bus_valid +1, earliest ack +2; requesters stall by holding req until ack/err.
module bus_arbiter #(
   parameter int ADDR_W         = 16,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              m1_req,
   input  logic              m1_mode,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic              m2_req,
   input  logic              m2_mode,
   input  logic [ADDR_W-1:0] m2_addr,
   input  logic              slv_done,
   output logic              m1_grant,
   output logic              m2_grant,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_mode,
   output logic              bus_valid,
   output logic [2:0]        slv_sel,
   output logic              m1_ack,
   output logic              m2_ack,
   output logic              m1_err,
   output logic              m2_err
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RELEASE} state_t;

   state_t            state, state_nxt;
   logic [1:0]        rst_sync;
   logic              rst_n_int;
   logic              last_m2, last_m2_nxt;
   logic              win_m2;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [3:0]        slv_id;
   logic [2:0]        sel_dec;
   logic              m1_grant_nxt, m2_grant_nxt, bus_mode_nxt, bus_valid_nxt;
   logic [ADDR_W-1:0] bus_addr_nxt;
   logic [2:0]        slv_sel_nxt;
   logic              m1_ack_nxt, m2_ack_nxt, m1_err_nxt, m2_err_nxt;

   // Assert asynchronously, release only after two clean clock edges.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) rst_sync <= 2'b00;
      else       rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n_int = rst_sync[1];

   assign slv_id = bus_addr[ADDR_W-1 -: 4];

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state     <= S_IDLE;
         last_m2   <= 1'b1;
         cnt       <= '0;
         m1_grant  <= 1'b0;
         m2_grant  <= 1'b0;
         bus_addr  <= '0;
         bus_mode  <= 1'b0;
         bus_valid <= 1'b0;
         slv_sel   <= 3'b000;
         m1_ack    <= 1'b0;
         m2_ack    <= 1'b0;
         m1_err    <= 1'b0;
         m2_err    <= 1'b0;
      end else begin
         state     <= state_nxt;
         last_m2   <= last_m2_nxt;
         cnt       <= cnt_nxt;
         m1_grant  <= m1_grant_nxt;
         m2_grant  <= m2_grant_nxt;
         bus_addr  <= bus_addr_nxt;
         bus_mode  <= bus_mode_nxt;
         bus_valid <= bus_valid_nxt;
         slv_sel   <= slv_sel_nxt;
         m1_ack    <= m1_ack_nxt;
         m2_ack    <= m2_ack_nxt;
         m1_err    <= m1_err_nxt;
         m2_err    <= m2_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      last_m2_nxt   = last_m2;
      cnt_nxt       = cnt;
      win_m2        = 1'b0;
      sel_dec       = 3'b000;
      m1_grant_nxt  = m1_grant;
      m2_grant_nxt  = m2_grant;
      bus_addr_nxt  = bus_addr;
      bus_mode_nxt  = bus_mode;
      bus_valid_nxt = bus_valid;
      slv_sel_nxt   = slv_sel;
      m1_ack_nxt    = 1'b0;
      m2_ack_nxt    = 1'b0;
      m1_err_nxt    = 1'b0;
      m2_err_nxt    = 1'b0;
      case (state)
         S_IDLE: begin
            if (m1_req || m2_req) begin
               // M2 wins when alone, or when both ask and M1 was served last.
               win_m2       = m2_req && (!m1_req || !last_m2);
               m1_grant_nxt = !win_m2;
               m2_grant_nxt = win_m2;
               bus_addr_nxt = win_m2 ? m2_addr : m1_addr;
               bus_mode_nxt = win_m2 ? m2_mode : m1_mode;
               last_m2_nxt  = win_m2;
               state_nxt    = S_ADDR;
            end
         end
         S_ADDR: begin
            case (slv_id)
               4'd0:    sel_dec = 3'b001;
               4'd1:    sel_dec = 3'b010;
               4'd2:    sel_dec = 3'b100;
               default: sel_dec = 3'b000;
            endcase
            if (sel_dec != 3'b000) begin
               slv_sel_nxt   = sel_dec;
               bus_valid_nxt = 1'b1;
               cnt_nxt       = '0;
               state_nxt     = S_DATA;
            end else begin
               m1_grant_nxt = 1'b0;
               m2_grant_nxt = 1'b0;
               m1_err_nxt   = m1_grant;
               m2_err_nxt   = m2_grant;
               state_nxt    = S_RELEASE;
            end
         end
         S_DATA: begin
            // A done strobe on the timeout cycle still counts as success.
            if (slv_done || cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               m1_ack_nxt    = slv_done && m1_grant;
               m2_ack_nxt    = slv_done && m2_grant;
               m1_err_nxt    = !slv_done && m1_grant;
               m2_err_nxt    = !slv_done && m2_grant;
               m1_grant_nxt  = 1'b0;
               m2_grant_nxt  = 1'b0;
               bus_valid_nxt = 1'b0;
               slv_sel_nxt   = 3'b000;
               state_nxt     = S_RELEASE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_RELEASE: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: a transaction-level model predicts each cycle's outputs.
module tb_bus_arbiter;
   localparam int T = 8;

   logic        clk = 1'b0;
   logic        rstn;
   logic        m1_req, m1_mode, m2_req, m2_mode, slv_done;
   logic [15:0] m1_addr, m2_addr;
   logic        m1_grant, m2_grant, bus_mode, bus_valid;
   logic [15:0] bus_addr;
   logic [2:0]  slv_sel;
   logic        m1_ack, m2_ack, m1_err, m2_err;

   int          checks = 0;
   int          errors = 0;
   bit          last_m2;
   logic [15:0] exp_addr;
   logic        exp_mode;

   bus_arbiter #(.ADDR_W(16), .TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
      .clk(clk), .rstn(rstn),
      .m1_req(m1_req), .m1_mode(m1_mode), .m1_addr(m1_addr),
      .m2_req(m2_req), .m2_mode(m2_mode), .m2_addr(m2_addr),
      .slv_done(slv_done),
      .m1_grant(m1_grant), .m2_grant(m2_grant),
      .bus_addr(bus_addr), .bus_mode(bus_mode), .bus_valid(bus_valid),
      .slv_sel(slv_sel),
      .m1_ack(m1_ack), .m2_ack(m2_ack), .m1_err(m1_err), .m2_err(m2_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // pulses = {m1_ack, m2_ack, m1_err, m2_err}
   task automatic expect_outs(input string tag, input logic [1:0] gnt, input logic valid,
                              input logic [2:0] sel, input logic [3:0] pulses);
      chk({tag, "_gnt"},   32'({m1_grant, m2_grant}), 32'(gnt));
      chk({tag, "_addr"},  32'(bus_addr), 32'(exp_addr));
      chk({tag, "_mode"},  32'(bus_mode), 32'(exp_mode));
      chk({tag, "_valid"}, 32'(bus_valid), 32'(valid));
      chk({tag, "_sel"},   32'(slv_sel), 32'(sel));
      chk({tag, "_pulse"}, 32'({m1_ack, m2_ack, m1_err, m2_err}), 32'(pulses));
   endtask

   function automatic logic [15:0] rand_addr();
      logic [3:0] id;
      id = ($urandom_range(0, 3) < 3) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(3, 15));
      return {id, 12'($urandom)};
   endfunction

   task automatic perturb(input bit churn);
      slv_done = 1'($urandom_range(0, 1));
      if (churn) begin
         m1_req  = 1'($urandom_range(0, 1));
         m2_req  = 1'($urandom_range(0, 1));
         m1_addr = rand_addr();
         m2_addr = rand_addr();
         m1_mode = 1'($urandom_range(0, 1));
         m2_mode = 1'($urandom_range(0, 1));
      end
   endtask

   // One whole transaction from an IDLE cycle; d = DATA cycle carrying slv_done (d > T: never).
   task automatic do_txn(input logic r1, input logic r2, input logic [15:0] a1, input logic [15:0] a2,
                         input logic md1, input logic md2, input int d, input bit churn);
      bit         w2;
      logic [1:0] gv;
      logic [2:0] sel;
      int         len;
      m1_req = r1; m2_req = r2; m1_addr = a1; m2_addr = a2; m1_mode = md1; m2_mode = md2;
      slv_done = 1'($urandom_range(0, 1));
      w2       = r2 && (!r1 || !last_m2);
      last_m2  = w2;
      gv       = w2 ? 2'b01 : 2'b10;
      exp_addr = w2 ? a2 : a1;
      exp_mode = w2 ? md2 : md1;
      case (exp_addr[15:12])
         4'd0:    sel = 3'b001;
         4'd1:    sel = 3'b010;
         4'd2:    sel = 3'b100;
         default: sel = 3'b000;
      endcase
      step();
      expect_outs("addr", gv, 1'b0, 3'b000, 4'b0000);
      perturb(churn);
      if (sel == 3'b000) begin
         step();
         expect_outs("decerr", 2'b00, 1'b0, 3'b000, w2 ? 4'b0001 : 4'b0010);
      end else begin
         len = (d <= T) ? d : T;
         for (int k = 1; k <= len; k++) begin
            step();
            expect_outs("data", gv, 1'b1, sel, 4'b0000);
            perturb(churn);
            slv_done = (k == d);
         end
         step();
         if (d <= T) expect_outs("ack", 2'b00, 1'b0, 3'b000, w2 ? 4'b0100 : 4'b1000);
         else        expect_outs("tmo", 2'b00, 1'b0, 3'b000, w2 ? 4'b0001 : 4'b0010);
      end
      perturb(churn);
      step();
      expect_outs("idle", 2'b00, 1'b0, 3'b000, 4'b0000);
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         m1_req = 1'b0;
         m2_req = 1'b0;
         slv_done = 1'($urandom_range(0, 1));
         step();
         expect_outs("gap", 2'b00, 1'b0, 3'b000, 4'b0000);
      end
   endtask

   initial begin
      bit found;
      rstn = 1'b0;
      m1_req = 1'b0; m2_req = 1'b0; m1_mode = 1'b0; m2_mode = 1'b0;
      m1_addr = '0; m2_addr = '0; slv_done = 1'b0;
      last_m2 = 1'b1; exp_addr = '0; exp_mode = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_outs("reset", 2'b00, 1'b0, 3'b000, 4'b0000);
      end
      rstn = 1'b1;
      idle_gap(4);

      // Both held from reset: M1, M2, M1, M2.
      for (int i = 0; i < 4; i++) do_txn(1'b1, 1'b1, 16'h1004, 16'h2008, 1'b0, 1'b1, 1, 1'b0);
      idle_gap(1);
      do_txn(1'b1, 1'b0, 16'h1230, 16'h0000, 1'b1, 1'b0, 3, 1'b0);
      do_txn(1'b0, 1'b1, 16'h0000, 16'h5000, 1'b0, 1'b0, 1, 1'b0);
      do_txn(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, T + 1, 1'b0);
      do_txn(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, T, 1'b0);

      for (int n = 0; n < 60; n++) begin
         logic r1, r2;
         r1 = 1'($urandom_range(0, 1));
         r2 = r1 ? 1'($urandom_range(0, 1)) : 1'b1;
         do_txn(r1, r2, rand_addr(), rand_addr(), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(1, T + 2), 1'b1);
         idle_gap($urandom_range(0, 2));
      end

      // Reset during the 2nd DATA cycle of an M2 transfer.
      m1_req = 1'b0; m2_req = 1'b1; m2_addr = 16'h0abc; m2_mode = 1'b1; slv_done = 1'b0;
      exp_addr = 16'h0abc; exp_mode = 1'b1; last_m2 = 1'b1;
      step();
      expect_outs("rst_addr", 2'b01, 1'b0, 3'b000, 4'b0000);
      step();
      expect_outs("rst_d1", 2'b01, 1'b1, 3'b001, 4'b0000);
      step();
      expect_outs("rst_d2", 2'b01, 1'b1, 3'b001, 4'b0000);
      #2 rstn = 1'b0;
      #1;
      exp_addr = '0; exp_mode = 1'b0;
      expect_outs("rst_async", 2'b00, 1'b0, 3'b000, 4'b0000);
      for (int i = 0; i < 2; i++) begin
         step();
         expect_outs("rst_hold", 2'b00, 1'b0, 3'b000, 4'b0000);
      end
      m1_req = 1'b1; m2_req = 1'b1; m1_addr = 16'h1234; m1_mode = 1'b0;
      rstn = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         step();
         if (m1_grant || m2_grant) found = 1'b1;
         else expect_outs("rst_wait", 2'b00, 1'b0, 3'b000, 4'b0000);
      end
      chk("rst_grant_seen", 32'(found), 32'd1);
      if (!found) begin
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
      exp_addr = 16'h1234; exp_mode = 1'b0;
      expect_outs("rst_first", 2'b10, 1'b0, 3'b000, 4'b0000);
      m1_req = 1'b0; m2_req = 1'b0; slv_done = 1'b0;
      step();
      expect_outs("rst_data", 2'b10, 1'b1, 3'b010, 4'b0000);
      slv_done = 1'b1;
      step();
      expect_outs("rst_ack", 2'b00, 1'b0, 3'b000, 4'b1000);
      slv_done = 1'b0;
      step();
      expect_outs("rst_idle", 2'b00, 1'b0, 3'b000, 4'b0000);
      last_m2 = 1'b0;

      for (int n = 0; n < 20; n++) begin
         do_txn(1'b1, 1'b1, rand_addr(), rand_addr(), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(1, T + 2), 1'b1);
         idle_gap($urandom_range(0, 1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
